debug_unit_controller: RTL and testbench

Command sequencer between the UART receive word assembler and the pipelined CPU. It decodes each completed 32-bit word from the receive side as a command or as instruction payload. It writes instruction memory, gates the CPU clock enable for continuous or single-step execution, and requests a register/memory dump from the transmit side after every step or halt.

---
 rtl/debug_unit_controller_pkg.sv | 38 +++
 rtl/debug_unit_controller.sv | 153 +++++++++++++++
 tb/tb_debug_unit_controller.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_unit_controller_pkg.sv
// Shared command-protocol definitions for the debug unit: opcodes, state codes and field positions.
// Also consumed by the transmit-side dump formatter and the host script generator.
package debug_unit_controller_pkg;

    localparam int CMD_WIDTH    = 32;
    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 24;
    localparam int ARG_MSB      = 15;
    localparam int ARG_LSB      = 0;
    localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int ARG_WIDTH    = ARG_MSB - ARG_LSB + 1;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [ARG_WIDTH-1:0]    arg_t;

    localparam opcode_t OP_LOAD = 8'h01;
    localparam opcode_t OP_RUN  = 8'h02;
    localparam opcode_t OP_STEP = 8'h03;
    localparam opcode_t OP_DUMP = 8'h04;

    // Encodings are visible on the debug LEDs, so they are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP      = 3'd3,
        ST_DUMP_WAIT = 3'd4
    } dbg_state_e;

    function automatic opcode_t cmd_opcode(input logic [CMD_WIDTH-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic arg_t cmd_arg(input logic [CMD_WIDTH-1:0] word);
        return word[ARG_MSB:ARG_LSB];
    endfunction

endpackage

// File: rtl/debug_unit_controller.sv
// Debug command sequencer: decodes received words, loads instruction memory,
// gates the CPU clock enable for run/step and requests a dump after each stop.
module debug_unit_controller
    import debug_unit_controller_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IMEM_ADDR_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [DATA_WIDTH-1:0]      i_word,
    input  logic                       i_word_valid,
    input  logic                       i_cpu_halt,
    input  logic                       i_dump_done,
    output logic                       o_imem_wr_en,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_imem_wr_data,
    output logic                       o_cpu_enable,
    output logic                       o_cpu_flush,
    output logic                       o_dump_req,
    output logic                       o_cmd_error,
    output logic [2:0]                 o_state
);

    typedef logic [ARG_WIDTH:0]           load_len_t;
    typedef logic [IMEM_ADDR_WIDTH-1:0]   addr_t;

    localparam load_len_t MAX_LOAD_WORDS = load_len_t'(2 ** IMEM_ADDR_WIDTH);
    localparam addr_t     ADDR_ONE       = addr_t'(1);

    dbg_state_e              state, state_nxt;
    addr_t                   addr_cnt, addr_cnt_nxt;
    addr_t                   last_addr, last_addr_nxt;
    logic                    wr_en_nxt;
    addr_t                   wr_addr_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt;
    logic                    enable_nxt;
    logic                    flush_nxt;
    logic                    dump_nxt;
    logic                    error_nxt;
    opcode_t                 opcode;
    arg_t                    arg;
    arg_t                    arg_minus_one;

    assign opcode        = cmd_opcode(i_word);
    assign arg           = cmd_arg(i_word);
    assign arg_minus_one = arg - arg_t'(1);
    assign o_state       = state;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt     = state;
        addr_cnt_nxt  = addr_cnt;
        last_addr_nxt = last_addr;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = o_imem_wr_addr;
        wr_data_nxt   = o_imem_wr_data;
        flush_nxt     = 1'b0;
        dump_nxt      = 1'b0;
        error_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_word_valid) begin
                    case (opcode)
                        OP_LOAD: begin
                            if ({1'b0, arg} > MAX_LOAD_WORDS) begin
                                error_nxt = 1'b1;
                            end else if (arg != '0) begin
                                // Storing N-1 keeps the full-depth load inside the address width.
                                last_addr_nxt = arg_minus_one[IMEM_ADDR_WIDTH-1:0];
                                addr_cnt_nxt  = '0;
                                flush_nxt     = 1'b1;
                                state_nxt     = ST_LOAD;
                            end
                        end
                        OP_RUN, OP_STEP: begin
                            if (i_cpu_halt) begin
                                dump_nxt  = 1'b1;
                                state_nxt = ST_DUMP_WAIT;
                            end else begin
                                state_nxt = (opcode == OP_RUN) ? ST_RUN : ST_STEP;
                            end
                        end
                        OP_DUMP: begin
                            dump_nxt  = 1'b1;
                            state_nxt = ST_DUMP_WAIT;
                        end
                        default: error_nxt = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                if (i_word_valid) begin
                    wr_en_nxt    = 1'b1;
                    wr_addr_nxt  = addr_cnt;
                    wr_data_nxt  = i_word;
                    addr_cnt_nxt = addr_cnt + ADDR_ONE;
                    if (addr_cnt == last_addr) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (i_cpu_halt) begin
                    dump_nxt  = 1'b1;
                    state_nxt = ST_DUMP_WAIT;
                end
            end
            ST_STEP: begin
                dump_nxt  = 1'b1;
                state_nxt = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (i_dump_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Enable is a pure function of the state being entered, so it is registered alongside it.
        enable_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            addr_cnt       <= '0;
            last_addr      <= '0;
            o_imem_wr_en   <= 1'b0;
            o_imem_wr_addr <= '0;
            o_imem_wr_data <= '0;
            o_cpu_enable   <= 1'b0;
            o_cpu_flush    <= 1'b0;
            o_dump_req     <= 1'b0;
            o_cmd_error    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state          <= state_nxt;
            addr_cnt       <= addr_cnt_nxt;
            last_addr      <= last_addr_nxt;
            o_imem_wr_en   <= wr_en_nxt;
            o_imem_wr_addr <= wr_addr_nxt;
            o_imem_wr_data <= wr_data_nxt;
            o_cpu_enable   <= enable_nxt;
            o_cpu_flush    <= flush_nxt;
            o_dump_req     <= dump_nxt;
            o_cmd_error    <= error_nxt;
        end
    end

endmodule

// File: tb/tb_debug_unit_controller.sv
// Self-checking bench for debug_unit_controller: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_debug_unit_controller;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_word = '0;
    logic        i_word_valid = 1'b0;
    logic        i_cpu_halt = 1'b0;
    logic        i_dump_done = 1'b0;
    logic        o_imem_wr_en;
    logic [7:0]  o_imem_wr_addr;
    logic [31:0] o_imem_wr_data;
    logic        o_cpu_enable;
    logic        o_cpu_flush;
    logic        o_dump_req;
    logic        o_cmd_error;
    logic [2:0]  o_state;

    debug_unit_controller #(.DATA_WIDTH(32), .IMEM_ADDR_WIDTH(8)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_word         (i_word),
        .i_word_valid   (i_word_valid),
        .i_cpu_halt     (i_cpu_halt),
        .i_dump_done    (i_dump_done),
        .o_imem_wr_en   (o_imem_wr_en),
        .o_imem_wr_addr (o_imem_wr_addr),
        .o_imem_wr_data (o_imem_wr_data),
        .o_cpu_enable   (o_cpu_enable),
        .o_cpu_flush    (o_cpu_flush),
        .o_dump_req     (o_dump_req),
        .o_cmd_error    (o_cmd_error),
        .o_state        (o_state)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: mode numbers are the externally visible state codes (0..4),
    // a LOAD tracks words still owed rather than a terminal address.
    typedef struct packed {
        int          mode;
        int          left;
        int          addr;
        logic        wr_en;
        logic [7:0]  wr_addr;
        logic [31:0] wr_data;
        logic        en;
        logic        flush;
        logic        dump;
        logic        err;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(input model_t cur, input logic v, input logic [31:0] w,
                                          input logic halt, input logic done);
        model_t n;
        int op;
        int arg;
        n = cur;
        op = int'(w[31:24]);
        arg = int'(w[15:0]);
        n.wr_en = 1'b0;
        n.flush = 1'b0;
        n.dump = 1'b0;
        n.err = 1'b0;
        case (cur.mode)
            0: if (v) begin
                if (op == 1) begin
                    if (arg > 256) n.err = 1'b1;
                    else if (arg > 0) begin
                        n.left = arg; n.addr = 0; n.flush = 1'b1; n.mode = 1;
                    end
                end else if (op == 2 || op == 3) begin
                    if (halt) begin n.dump = 1'b1; n.mode = 4; end
                    else n.mode = op;
                end else if (op == 4) begin
                    n.dump = 1'b1; n.mode = 4;
                end else begin
                    n.err = 1'b1;
                end
            end
            1: if (v) begin
                n.wr_en = 1'b1;
                n.wr_addr = 8'(cur.addr);
                n.wr_data = w;
                n.addr = (cur.addr + 1) % 256;
                n.left = cur.left - 1;
                if (n.left == 0) n.mode = 0;
            end
            2: if (halt) begin n.dump = 1'b1; n.mode = 4; end
            3: begin n.dump = 1'b1; n.mode = 4; end
            4: if (done) n.mode = 0;
            default: n.mode = 0;
        endcase
        n.en = (n.mode == 2) || (n.mode == 3);
        return n;
    endfunction

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) m <= '0;
        else m <= model_next(m, i_word_valid, i_word, i_cpu_halt, i_dump_done);
    end

    // Event log used by the directed scenarios.
    logic        cmp_en = 1'b0;
    int          wr_cnt = 0;
    int          flush_cnt = 0;
    int          dump_cnt = 0;
    int          err_cnt = 0;
    int          en_cnt = 0;
    logic [7:0]  wr_addr_log [4096];
    logic [31:0] wr_data_log [4096];

    initial forever begin
        @(negedge i_clk);
        if (cmp_en) begin
            check("ctrl{state,en,flush,dump,err,wr_en}",
                  {o_state, o_cpu_enable, o_cpu_flush, o_dump_req, o_cmd_error, o_imem_wr_en},
                  {m.mode[2:0], m.en, m.flush, m.dump, m.err, m.wr_en});
            if (m.wr_en)
                check("wr{addr,data}", {o_imem_wr_addr, o_imem_wr_data}, {m.wr_addr, m.wr_data});
        end
        if (o_imem_wr_en) begin
            if (wr_cnt < 4096) begin
                wr_addr_log[wr_cnt] = o_imem_wr_addr;
                wr_data_log[wr_cnt] = o_imem_wr_data;
            end
            wr_cnt++;
        end
        if (o_cpu_flush)  flush_cnt++;
        if (o_dump_req)   dump_cnt++;
        if (o_cmd_error)  err_cnt++;
        if (o_cpu_enable) en_cnt++;
    end

    // Inputs applied now are sampled at the next rising edge; returns 1 time unit after it.
    task automatic cyc(input logic v, input logic [31:0] w, input logic d);
        i_word_valid = v;
        i_word = w;
        i_dump_done = d;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] gen_word();
        int sel;
        logic [31:0] w;
        sel = int'($urandom_range(0, 9));
        w = $urandom;
        case (sel)
            0, 1: begin
                case ($urandom_range(0, 3))
                    0: w = 32'h0100_0000;
                    1: w = 32'h0100_0101;
                    default: w = 32'h0100_0000 | 32'($urandom_range(1, 6));
                endcase
            end
            2: w = 32'h0200_0000 | 32'($urandom_range(0, 255));
            3: w = 32'h0300_0000;
            4: w = 32'h0400_0000;
            5: w = {8'($urandom_range(5, 255)), w[23:0]};
            default: ;
        endcase
        return w;
    endfunction

    int b_w, b_f, b_d, b_e, b_en;

    task automatic snap();
        b_w = wr_cnt; b_f = flush_cnt; b_d = dump_cnt; b_e = err_cnt; b_en = en_cnt;
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_outputs",
              {o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data, o_cpu_enable, o_cpu_flush,
               o_dump_req, o_cmd_error, o_state}, 64'd0);
        i_reset = 1'b0;
        cmp_en = 1'b1;
        cyc(1'b0, '0, 1'b0);

        // LOAD N=3 with three payload words.
        snap();
        cyc(1'b1, 32'h0100_0003, 1'b0);
        check("load3_flush_now", o_cpu_flush, 1'b1);
        cyc(1'b1, 32'hAAAA_0001, 1'b0);
        cyc(1'b1, 32'hAAAA_0002, 1'b0);
        cyc(1'b1, 32'hAAAA_0003, 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("load3_writes", wr_cnt - b_w, 3);
        check("load3_flushes", flush_cnt - b_f, 1);
        for (int i = 0; i < 3; i++) begin
            check("load3_addr", wr_addr_log[b_w + i], 64'(i));
            check("load3_data", wr_data_log[b_w + i], 64'(32'hAAAA_0001 + i));
        end
        check("load3_state", o_state, 3'd0);

        // LOAD N=0: next word is a command with a bad opcode.
        snap();
        cyc(1'b1, 32'h0100_0000, 1'b0);
        cyc(1'b1, 32'h1234_5678, 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("load0_writes", wr_cnt - b_w, 0);
        check("load0_errors", err_cnt - b_e, 1);
        check("load0_flushes", flush_cnt - b_f, 0);

        // LOAD N=257 is oversize.
        snap();
        cyc(1'b1, 32'h0100_0101, 1'b0);
        check("load257_err_now", o_cmd_error, 1'b1);
        cyc(1'b0, '0, 1'b0);
        check("load257_flushes", flush_cnt - b_f, 0);
        check("load257_state", o_state, 3'd0);

        // LOAD N=256 fills the whole memory, back to back.
        snap();
        cyc(1'b1, 32'h0100_0100, 1'b0);
        for (int i = 0; i < 256; i++) cyc(1'b1, 32'hC0DE_0000 + 32'(i), 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("load256_writes", wr_cnt - b_w, 256);
        check("load256_first_addr", wr_addr_log[b_w], 8'h00);
        check("load256_last_addr", wr_addr_log[b_w + 255], 8'hFF);
        check("load256_last_data", wr_data_log[b_w + 255], 32'hC0DE_00FF);
        check("load256_state", o_state, 3'd0);

        // RUN, halt sampled 10 cycles after the RUN word.
        snap();
        cyc(1'b1, 32'h0200_0000, 1'b0);
        check("run_enable_rise", {o_state, o_cpu_enable}, {3'd2, 1'b1});
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'h0400_0000, 1'b0);
        i_cpu_halt = 1'b1;
        cyc(1'b0, '0, 1'b0);
        check("run_halt_dump", {o_state, o_cpu_enable, o_dump_req}, {3'd4, 1'b0, 1'b1});
        i_cpu_halt = 1'b0;
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        check("run_done_state", o_state, 3'd0);
        check("run_enable_cycles", en_cnt - b_en, 10);
        check("run_dumps", dump_cnt - b_d, 1);

        // Three STEPs; words in DUMP_WAIT (including one alongside dump_done) are ignored.
        snap();
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, 32'h0300_0000, 1'b0);
            check("step_enable", {o_state, o_cpu_enable, o_dump_req}, {3'd3, 1'b1, 1'b0});
            cyc(1'b0, '0, 1'b0);
            check("step_dump", {o_state, o_cpu_enable, o_dump_req}, {3'd4, 1'b0, 1'b1});
            cyc(1'b1, 32'h0200_0000, 1'b0);
            check("step_word_ignored", o_state, 3'd4);
            cyc(1'b1, 32'h0200_0000, 1'b1);
            check("step_done_idle", {o_state, o_cpu_enable}, {3'd0, 1'b0});
        end
        check("step_enable_cycles", en_cnt - b_en, 3);
        check("step_dumps", dump_cnt - b_d, 3);

        // STEP and RUN while halt is already high: dump without any enable cycle.
        snap();
        i_cpu_halt = 1'b1;
        cyc(1'b1, 32'h0300_0000, 1'b0);
        check("halted_step", {o_state, o_cpu_enable, o_dump_req}, {3'd4, 1'b0, 1'b1});
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 32'h0200_0000, 1'b0);
        check("halted_run", {o_state, o_cpu_enable, o_dump_req}, {3'd4, 1'b0, 1'b1});
        i_cpu_halt = 1'b0;
        cyc(1'b0, '0, 1'b1);
        check("halted_no_enable", en_cnt - b_en, 0);

        // Reset after 2 of 5 LOAD words, then RUN accepted from IDLE.
        cyc(1'b1, 32'h0100_0005, 1'b0);
        cyc(1'b1, 32'h5555_0000, 1'b0);
        cyc(1'b1, 32'h5555_0001, 1'b0);
        check("preload_wr_en", o_imem_wr_en, 1'b1);
        i_reset = 1'b1;
        #1;
        check("reset_midload_outputs",
              {o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data, o_cpu_enable, o_cpu_flush,
               o_dump_req, o_cmd_error, o_state}, 64'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        cyc(1'b1, 32'h0200_0000, 1'b0);
        check("post_reset_run", {o_state, o_cpu_enable}, {3'd2, 1'b1});
        i_cpu_halt = 1'b1;
        cyc(1'b0, '0, 1'b0);
        i_cpu_halt = 1'b0;
        cyc(1'b0, '0, 1'b1);
        check("post_reset_idle", o_state, 3'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) i_cpu_halt = ~i_cpu_halt;
            if ($urandom_range(0, 799) == 0) begin
                i_reset = 1'b1;
                cyc(1'b0, '0, 1'b0);
                i_reset = 1'b0;
            end else begin
                cyc(1'($urandom_range(0, 1)), gen_word(), 1'($urandom_range(0, 5) == 0));
            end
        end
        i_cpu_halt = 1'b0;
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
